// File: rtl/ycbcr_target_locator.sv
// Chroma-window target locator: per-pixel mask plus per-frame bounding box, centre and hit count.
// Optional macro TARGET_Y_GATE_EN additionally gates the hit test with a luma window.
module ycbcr_target_locator #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter logic [7:0]  CB_MIN     = 8'd77,
    parameter logic [7:0]  CB_MAX     = 8'd127,
    parameter logic [7:0]  CR_MIN     = 8'd133,
    parameter logic [7:0]  CR_MAX     = 8'd173,
    parameter logic [7:0]  Y_MIN      = 8'd40,
    parameter logic [7:0]  Y_MAX      = 8'd235,
    parameter int unsigned MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_y_8b,
    input  logic [7:0]  i_cb_8b,
    input  logic [7:0]  i_cr_8b,
    input  logic        i_h_sync,
    input  logic        i_v_sync,
    input  logic        i_data_en,
    output logic        o_mask,
    output logic        o_mask_en,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic [10:0] o_x_min,
    output logic [10:0] o_x_max,
    output logic [10:0] o_y_min,
    output logic [10:0] o_y_max,
    output logic [10:0] o_x_center,
    output logic [10:0] o_y_center,
    output logic [19:0] o_pix_cnt,
    output logic        o_found,
    output logic        o_result_valid
);

    typedef enum logic [1:0] {StIdle, StActive, StReport} state_e;

    state_e      state_q, state_d;
    logic        in_active, in_report;
    logic        v_sync_d, de_d, h_sync_d, mask_q;
    logic        vs_rise, de_fall;
    logic        luma_ok, hit, counted;
    logic [10:0] x_q, y_q;
    logic [10:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
    logic [19:0] acc_cnt;
    logic        acc_found;
    logic [11:0] x_sum, y_sum;

    assign vs_rise = i_v_sync & ~v_sync_d;
    assign de_fall = de_d & ~i_data_en;

`ifdef TARGET_Y_GATE_EN
    assign luma_ok = (i_y_8b >= Y_MIN) && (i_y_8b <= Y_MAX);
`else
    logic unused_luma;
    assign unused_luma = ^{i_y_8b, Y_MIN, Y_MAX};
    assign luma_ok     = 1'b1;
`endif

    assign hit = luma_ok && (i_cb_8b >= CB_MIN) && (i_cb_8b <= CB_MAX)
                 && (i_cr_8b >= CR_MIN) && (i_cr_8b <= CR_MAX);

    // A pixel coinciding with the frame edge belongs to neither frame.
    assign counted = hit && i_data_en && in_active && !vs_rise
                     && (x_q < 11'(H_ACTIVE)) && (y_q < 11'(V_ACTIVE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (vs_rise) state_d = StActive;
            StActive: if (vs_rise) state_d = StReport;
            StReport: state_d = StActive;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        in_active = 1'b0;
        in_report = 1'b0;
        case (state_q)
            StActive: in_active = 1'b1;
            StReport: in_report = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sync_d <= 1'b0;
            h_sync_d <= 1'b0;
            de_d     <= 1'b0;
            mask_q   <= 1'b0;
        end else begin
            v_sync_d <= i_v_sync;
            h_sync_d <= i_h_sync;
            de_d     <= i_data_en;
            mask_q   <= hit & i_data_en;
        end
    end

    assign o_mask    = mask_q;
    assign o_mask_en = de_d;
    assign o_h_sync  = h_sync_d;
    assign o_v_sync  = v_sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (vs_rise || in_report || de_fall) x_q <= '0;
            else if (i_data_en && (x_q != 11'h7FF)) x_q <= x_q + 11'd1;

            if (vs_rise || in_report) y_q <= '0;
            else if (de_fall && (y_q != 11'h7FF)) y_q <= y_q + 11'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_x_min <= 11'h7FF;
            acc_x_max <= '0;
            acc_y_min <= 11'h7FF;
            acc_y_max <= '0;
            acc_cnt   <= '0;
        end else if (in_report) begin
            acc_x_min <= 11'h7FF;
            acc_x_max <= '0;
            acc_y_min <= 11'h7FF;
            acc_y_max <= '0;
            acc_cnt   <= '0;
        end else if (counted) begin
            if (x_q < acc_x_min) acc_x_min <= x_q;
            if (x_q > acc_x_max) acc_x_max <= x_q;
            if (y_q < acc_y_min) acc_y_min <= y_q;
            if (y_q > acc_y_max) acc_y_max <= y_q;
            if (acc_cnt != 20'hFFFFF) acc_cnt <= acc_cnt + 20'd1;
        end
    end

    assign acc_found = acc_cnt >= 20'(MIN_PIXELS);
    assign x_sum     = {1'b0, acc_x_min} + {1'b0, acc_x_max};
    assign y_sum     = {1'b0, acc_y_min} + {1'b0, acc_y_max};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_x_min        <= '0;
            o_x_max        <= '0;
            o_y_min        <= '0;
            o_y_max        <= '0;
            o_x_center     <= '0;
            o_y_center     <= '0;
            o_pix_cnt      <= '0;
            o_found        <= 1'b0;
            o_result_valid <= 1'b0;
        end else begin
            o_result_valid <= in_report;
            if (in_report) begin
                o_pix_cnt <= acc_cnt;
                o_found   <= acc_found;
                if (acc_found) begin
                    o_x_min    <= acc_x_min;
                    o_x_max    <= acc_x_max;
                    o_y_min    <= acc_y_min;
                    o_y_max    <= acc_y_max;
                    o_x_center <= 11'(x_sum >> 1);
                    o_y_center <= 11'(y_sum >> 1);
                end else begin
                    o_x_min    <= '0;
                    o_x_max    <= '0;
                    o_y_min    <= '0;
                    o_y_max    <= '0;
                    o_x_center <= '0;
                    o_y_center <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_target_locator.sv
// Directed bench for ycbcr_target_locator: reset, block frame, too-few-hits, window edges,
// out-of-range pixels, luma gate and mid-frame reset.
module tb_ycbcr_target_locator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_y_8b, i_cb_8b, i_cr_8b;
    logic        i_h_sync, i_v_sync, i_data_en;
    logic        o_mask, o_mask_en, o_h_sync, o_v_sync;
    logic [10:0] o_x_min, o_x_max, o_y_min, o_y_max, o_x_center, o_y_center;
    logic [19:0] o_pix_cnt;
    logic        o_found, o_result_valid;

    int n_vec = 0;
    int n_err = 0;

`ifdef TARGET_Y_GATE_EN
    localparam bit Gate = 1'b1;
`else
    localparam bit Gate = 1'b0;
`endif

    ycbcr_target_locator dut (
        .clk            (clk),
        .rst            (rst),
        .i_y_8b         (i_y_8b),
        .i_cb_8b        (i_cb_8b),
        .i_cr_8b        (i_cr_8b),
        .i_h_sync       (i_h_sync),
        .i_v_sync       (i_v_sync),
        .i_data_en      (i_data_en),
        .o_mask         (o_mask),
        .o_mask_en      (o_mask_en),
        .o_h_sync       (o_h_sync),
        .o_v_sync       (o_v_sync),
        .o_x_min        (o_x_min),
        .o_x_max        (o_x_max),
        .o_y_min        (o_y_min),
        .o_y_max        (o_y_max),
        .o_x_center     (o_x_center),
        .o_y_center     (o_y_center),
        .o_pix_cnt      (o_pix_cnt),
        .o_found        (o_found),
        .o_result_valid (o_result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        i_y_8b  = y;
        i_cb_8b = cb;
        i_cr_8b = cr;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mask"}, o_mask, 0);
        chk({tag, "_mask_en"}, o_mask_en, 0);
        chk({tag, "_hs"}, o_h_sync, 0);
        chk({tag, "_vs"}, o_v_sync, 0);
        chk({tag, "_box"}, {o_x_min, o_x_max, o_y_min, o_y_max} != 0, 0);
        chk({tag, "_ctr"}, {o_x_center, o_y_center}, 0);
        chk({tag, "_cnt"}, o_pix_cnt, 0);
        chk({tag, "_found"}, o_found, 0);
        chk({tag, "_valid"}, o_result_valid, 0);
    endtask

    // n enabled pixels, hits at lo..hi, then data_en drops for two cycles.
    task automatic drive_line(input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) begin
            i_data_en = 1'b1;
            if (i >= lo && i <= hi) px(8'd128, 8'd100, 8'd150);
            else                    px(8'd128, 8'd0, 8'd0);
            step();
        end
        i_data_en = 1'b0;
        px(8'd128, 8'd0, 8'd0);
        step();
        step();
    endtask

    task automatic frame_edge(input string tag, input bit de_on_edge, input bit exp_rep,
                              input int xmin, input int xmax, input int ymin, input int ymax,
                              input int xc, input int yc, input int cnt, input bit found);
        i_v_sync = 1'b1;
        if (de_on_edge) begin
            i_data_en = 1'b1;
            px(8'd128, 8'd100, 8'd150);
        end
        step();
        chk({tag, "_valid_n"}, o_result_valid, 0);
        chk({tag, "_vsync_fwd"}, o_v_sync, 1);
        step();
        chk({tag, "_valid_n1"}, o_result_valid, exp_rep);
        if (exp_rep) begin
            chk({tag, "_x_min"}, o_x_min, xmin);
            chk({tag, "_x_max"}, o_x_max, xmax);
            chk({tag, "_y_min"}, o_y_min, ymin);
            chk({tag, "_y_max"}, o_y_max, ymax);
            chk({tag, "_x_ctr"}, o_x_center, xc);
            chk({tag, "_y_ctr"}, o_y_center, yc);
            chk({tag, "_cnt"}, o_pix_cnt, cnt);
            chk({tag, "_found"}, o_found, found);
        end
        i_v_sync  = 1'b0;
        i_data_en = 1'b0;
        px(8'd128, 8'd0, 8'd0);
        step();
        chk({tag, "_valid_n2"}, o_result_valid, 0);
        step();
    endtask

    initial begin
        rst       = 1'b1;
        i_h_sync  = 1'b0;
        i_v_sync  = 1'b0;
        i_data_en = 1'b0;
        px(8'd128, 8'd0, 8'd0);
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // First edge only opens a frame.
        frame_edge("start", 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

        // Frame A: 20x10 block at x=100..119, y=50..59.
        for (int y = 0; y < 60; y++) begin
            if (y < 50) drive_line(130, 1, 0);
            else        drive_line(130, 100, 119);
        end
        frame_edge("block", 1'b0, 1'b1, 100, 119, 50, 59, 109, 54, 200, 1'b1);

        // Frame B: window edges on line 0, then 62 more hits on line 1 (63 total).
        chk("hold_cnt", o_pix_cnt, 200);
        chk("hold_xmin", o_x_min, 100);
        i_data_en = 1'b1;
        px(8'd128, 8'd77, 8'd173);
        chk("mask_latency", o_mask, 0);
        step();
        chk("cbmin_crmax", o_mask, 1);
        chk("mask_en", o_mask_en, 1);
        px(8'd128, 8'd128, 8'd150);
        i_h_sync = 1'b1;
        step();
        chk("cbmax_plus1", o_mask, 0);
        chk("hsync_fwd", o_h_sync, 1);
        px(8'd128, 8'd77, 8'd174);
        i_h_sync = 1'b0;
        step();
        chk("crmax_plus1", o_mask, 0);
        chk("hsync_low", o_h_sync, 0);
        px(8'd128, 8'd76, 8'd133);
        step();
        chk("cbmin_minus1", o_mask, 0);
        i_data_en = 1'b0;
        px(8'd128, 8'd0, 8'd0);
        step();
        chk("mask_en_low", o_mask_en, 0);
        step();
        drive_line(70, 0, 61);
        frame_edge("few", 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 63, 1'b0);

        // Frame C: 700-wide hit line, then one low-luma chroma hit on line 1.
        drive_line(700, 0, 699);
        i_data_en = 1'b1;
        px(8'd20, 8'd100, 8'd150);
        step();
        chk("luma_gate", o_mask, Gate ? 0 : 1);
        i_data_en = 1'b0;
        px(8'd128, 8'd0, 8'd0);
        step();
        step();
        frame_edge("wide", 1'b0, 1'b1, 0, 639, 0, Gate ? 0 : 1, 319, 0, Gate ? 640 : 641, 1'b1);

        // Reset in the middle of a line.
        i_data_en = 1'b1;
        px(8'd128, 8'd100, 8'd150);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        #2;
        chk_all_zero("rst_async");
        step();
        chk_all_zero("rst_held");
        i_data_en = 1'b0;
        px(8'd128, 8'd0, 8'd0);
        rst = 1'b0;
        step();
        frame_edge("post_rst_start", 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        drive_line(90, 10, 79);
        // Hit pixels on the edge cycle and the report cycle must not count.
        frame_edge("post_rst", 1'b1, 1'b1, 10, 79, 0, 0, 44, 0, 70, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
